// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, addresses the combinational
// instruction ROM, and queues {PC, instruction, fault} entries in a circular
// prefetch FIFO for decode. Redirects flush the queue and restart fetch; the
// out-of-bounds sentinel word halts fetch until the next redirect or reset.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] OOB_WORD = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_a,
  input  logic [31:0]              imem_rd,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic                     out_fault,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } state_e;

  state_e          state_q, state_d;
  logic            halted_q, halted_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;

  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic [DEPTH-1:0] fault_mem_q;

  logic            is_oob;
  logic            pop_req;
  logic            deq;
  logic            can_enq;
  logic            push;
  logic            unused_pc_bits;

  // The low redirect bits are dropped: fetch is always word aligned.
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign is_oob    = (imem_rd == OOB_WORD);
  assign out_valid = (level_q != '0);
  assign pop_req   = out_valid & out_ready;
  // A redirect suppresses both sides of the FIFO for its cycle.
  assign deq       = pop_req & ~redirect_valid;
  assign can_enq   = (level_q < LW'(DEPTH)) | pop_req;
  assign push      = (state_q == ST_RUN) & ~redirect_valid & can_enq;

  assign imem_a    = fetch_pc_q;
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_fault = out_valid & fault_mem_q[rd_ptr_q];
  assign halted    = halted_q;
  assign level     = level_q;

  // Next-state: redirect flushes and reloads the PC; otherwise push/pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (redirect_valid) begin
      state_d    = ST_RUN;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        if (is_oob) begin
          state_d = ST_HALT;
        end else begin
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !deq) begin
        level_d = level_q + LW'(1);
      end else if (deq && !push) begin
        level_d = level_q - LW'(1);
      end
    end
    halted_d = (state_d == ST_HALT);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      halted_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rd;
      fault_mem_q[wr_ptr_q] <= is_oob;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: a vector table of per-cycle inputs with
// hand-computed post-edge outputs, plus a hand-written halt/reset sequence.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        halted;
  logic [2:0]  level;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ifetch_ctrl #(
    .RESET_PC(32'h00400000),
    .DEPTH(4),
    .OOB_WORD(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_a(imem_a),
    .imem_rd(imem_rd),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_fault(out_fault),
    .halted(halted),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: 41 words at 0x00400000..0x004000A0, sentinel everywhere else.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    if (a < 32'h00400000 || a[1:0] != 2'b00) return 32'hDEADBEEF;
    idx = (a - 32'h00400000) >> 2;
    if (idx > 32'd40) return 32'hDEADBEEF;
    case (idx)
      32'd0:   return 32'h00600413;
      32'd1:   return 32'h00400493;
      32'd2:   return 32'h00940933;
      32'd8:   return 32'h00500413;
      32'd40:  return 32'h409409B3;
      default: return (idx << 20) | 32'h00000013;
    endcase
  endfunction

  assign imem_rd = rom_word(imem_a);

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_fault;
    logic        e_halt;
    logic [2:0]  e_level;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic rdy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] ei, input logic ef, input logic eh,
                     input logic [2:0] el, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_pc = epc; v.e_instr = ei; v.e_fault = ef;
    v.e_halt = eh; v.e_level = el; v.e_addr = ea;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v.e_valid});
    chk({tag, ".pc"},    out_pc,    v.e_pc);
    chk({tag, ".instr"}, out_instr, v.e_instr);
    chk({tag, ".fault"}, {31'd0, out_fault}, {31'd0, v.e_fault});
    chk({tag, ".halt"},  {31'd0, halted},    {31'd0, v.e_halt});
    chk({tag, ".level"}, {29'd0, level},     {29'd0, v.e_level});
    chk({tag, ".addr"},  imem_a,    v.e_addr);
  endtask

  initial begin
    vec_t hv;
    int unsigned waited;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    //   rst rv rpc           rdy  val pc            instr         flt hlt lvl addr
    // Reset release with out_ready=1: one entry per cycle in order.
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0, 0, 0, 32'h00400000);
    add(0, 0, 32'h0,        1,   1, 32'h00400000, 32'h00600413, 0, 0, 1, 32'h00400004);
    add(0, 0, 32'h0,        1,   1, 32'h00400004, 32'h00400493, 0, 0, 1, 32'h00400008);
    add(0, 0, 32'h0,        1,   1, 32'h00400008, 32'h00940933, 0, 0, 1, 32'h0040000C);
    // Back-pressure: fill to 4, hold at 0x10, then drain at full throughput.
    add(1, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0, 0, 0, 32'h00400000);
    add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00600413, 0, 0, 1, 32'h00400004);
    add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00600413, 0, 0, 2, 32'h00400008);
    add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00600413, 0, 0, 3, 32'h0040000C);
    for (int i = 0; i < 7; i++)
      add(0, 0, 32'h0,      0,   1, 32'h00400000, 32'h00600413, 0, 0, 4, 32'h00400010);
    add(0, 0, 32'h0,        1,   1, 32'h00400004, 32'h00400493, 0, 0, 4, 32'h00400014);
    add(0, 0, 32'h0,        1,   1, 32'h00400008, 32'h00940933, 0, 0, 4, 32'h00400018);
    add(0, 0, 32'h0,        1,   1, 32'h0040000C, 32'h00300013, 0, 0, 4, 32'h0040001C);
    add(0, 0, 32'h0,        1,   1, 32'h00400010, 32'h00400013, 0, 0, 4, 32'h00400020);
    add(0, 0, 32'h0,        1,   1, 32'h00400014, 32'h00500013, 0, 0, 4, 32'h00400024);
    // Redirect to misaligned 0x22 with 3 queued: flush, restart at 0x20.
    add(1, 0, 32'h0,        0,   0, 32'h0,        32'h0,        0, 0, 0, 32'h00400000);
    add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00600413, 0, 0, 1, 32'h00400004);
    add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00600413, 0, 0, 2, 32'h00400008);
    add(0, 0, 32'h0,        0,   1, 32'h00400000, 32'h00600413, 0, 0, 3, 32'h0040000C);
    add(0, 1, 32'h00400022, 1,   0, 32'h0,        32'h0,        0, 0, 0, 32'h00400020);
    add(0, 0, 32'h0,        1,   1, 32'h00400020, 32'h00500413, 0, 0, 1, 32'h00400024);
    add(0, 0, 32'h0,        1,   1, 32'h00400024, 32'h00900013, 0, 0, 1, 32'h00400028);
    // Full FIFO, out_ready=1 and redirect together: flush wins.
    add(0, 0, 32'h0,        0,   1, 32'h00400024, 32'h00900013, 0, 0, 2, 32'h0040002C);
    add(0, 0, 32'h0,        0,   1, 32'h00400024, 32'h00900013, 0, 0, 3, 32'h00400030);
    add(0, 0, 32'h0,        0,   1, 32'h00400024, 32'h00900013, 0, 0, 4, 32'h00400034);
    add(0, 1, 32'h00400000, 1,   0, 32'h0,        32'h0,        0, 0, 0, 32'h00400000);
    add(0, 0, 32'h0,        1,   1, 32'h00400000, 32'h00600413, 0, 0, 1, 32'h00400004);
    // End of ROM: sentinel entry faults and halts; redirect resumes.
    add(0, 1, 32'h00400098, 1,   0, 32'h0,        32'h0,        0, 0, 0, 32'h00400098);
    add(0, 0, 32'h0,        1,   1, 32'h00400098, 32'h02600013, 0, 0, 1, 32'h0040009C);
    add(0, 0, 32'h0,        1,   1, 32'h0040009C, 32'h02700013, 0, 0, 1, 32'h004000A0);
    add(0, 0, 32'h0,        1,   1, 32'h004000A0, 32'h409409B3, 0, 0, 1, 32'h004000A4);
    add(0, 0, 32'h0,        1,   1, 32'h004000A4, 32'hDEADBEEF, 1, 1, 1, 32'h004000A4);
    add(0, 0, 32'h0,        0,   1, 32'h004000A4, 32'hDEADBEEF, 1, 1, 1, 32'h004000A4);
    add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0, 1, 0, 32'h004000A4);
    add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0, 1, 0, 32'h004000A4);
    add(0, 1, 32'h00400000, 1,   0, 32'h0,        32'h0,        0, 0, 0, 32'h00400000);
    add(0, 0, 32'h0,        1,   1, 32'h00400000, 32'h00600413, 0, 0, 1, 32'h00400004);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].rv, vq[i].rpc, vq[i].rdy);
      chk_all($sformatf("v%0d", i), vq[i]);
    end

    // Reset while halted with two entries queued.
    drive(0, 1, 32'h004000A2, 0);
    chk("hs.redir_addr", imem_a, 32'h004000A0);
    waited = 0;
    while (!halted && waited < 8) begin
      drive(0, 0, 32'h0, 0);
      waited++;
    end
    chk("hs.halt_wait", {31'd0, halted}, 32'd1);
    hv.e_valid = 1; hv.e_pc = 32'h004000A0; hv.e_instr = 32'h409409B3;
    hv.e_fault = 0; hv.e_halt = 1; hv.e_level = 3'd2; hv.e_addr = 32'h004000A4;
    chk_all("hs.halted", hv);
    drive(1, 0, 32'h0, 0);
    hv.e_valid = 0; hv.e_pc = 32'h0; hv.e_instr = 32'h0;
    hv.e_fault = 0; hv.e_halt = 0; hv.e_level = 3'd0; hv.e_addr = 32'h00400000;
    chk_all("hs.reset", hv);
    drive(0, 0, 32'h0, 0);
    hv.e_valid = 1; hv.e_pc = 32'h00400000; hv.e_instr = 32'h00600413;
    hv.e_level = 3'd1; hv.e_addr = 32'h00400004;
    chk_all("hs.restart", hv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
